// File: rtl/fexp2_bf16.sv
// Iterative bfloat16 antilog: result_o = 2^x. It splits x into floor n and fraction f,
// then runs a shift-add loop for 2^f, one constant per cycle. A single operation is in flight.
module fexp2_bf16 #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 7,
  parameter int BIAS      = 127,
  parameter int FRAC_W    = 14,
  parameter int GRD_W     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [15:0] data_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [15:0] result_o,
  output logic        invalid_o,
  output logic        overflow_o,
  output logic        underflow_o
);

  localparam int R_W   = FRAC_W + GRD_W;          // residual width, Q0.R_W
  localparam int Y_W   = R_W + 2;                 // Q1.R_W plus one headroom bit
  localparam int X_W   = 1 + EXP_WIDTH + FRAC_W;  // signed fixed-point operand
  localparam int MAG_W = X_W - 1;
  localparam int N_W   = 1 + EXP_WIDTH;
  localparam int E_W   = EXP_WIDTH + 2;
  localparam int K_W   = $clog2(FRAC_W + 1);

  localparam logic [EXP_WIDTH-1:0] EXP_ONE = EXP_WIDTH'(BIAS - MAN_WIDTH);
  localparam logic [EXP_WIDTH-1:0] EXP_MIN = EXP_WIDTH'(BIAS - FRAC_W);
  localparam logic [EXP_WIDTH-1:0] EXP_OVF = EXP_WIDTH'(BIAS + 7);
  localparam logic [EXP_WIDTH-1:0] EXP_ALL = '1;

  localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_WIDTH) - 1);
  localparam logic signed [E_W-1:0] E_ZERO = '0;

  localparam logic [15:0] QNAN    = 16'h7FC0;
  localparam logic [15:0] POS_INF = 16'h7F80;
  localparam logic [15:0] ONE     = 16'h3F80;
  localparam logic [15:0] ZERO    = 16'h0000;

  typedef enum logic [1:0] {IDLE, ITER, NORM, DONE} state_t;

  state_t                 state_q, state_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [R_W-1:0]         r_q, r_d;
  logic [Y_W-1:0]         y_q, y_d;
  logic signed [N_W-1:0]  n_q, n_d;
  logic [15:0]            result_q, result_d;
  logic                   invalid_q, invalid_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;

  // round(log2(1 + 2^-k) * 2^R_W) for the R_W = 16 residual.
  function automatic logic [R_W-1:0] lk_const(input logic [K_W-1:0] k);
    logic [R_W-1:0] v;
    case (k)
      K_W'(1):  v = R_W'(38336);
      K_W'(2):  v = R_W'(21098);
      K_W'(3):  v = R_W'(11136);
      K_W'(4):  v = R_W'(5732);
      K_W'(5):  v = R_W'(2909);
      K_W'(6):  v = R_W'(1466);
      K_W'(7):  v = R_W'(736);
      K_W'(8):  v = R_W'(369);
      K_W'(9):  v = R_W'(184);
      K_W'(10): v = R_W'(92);
      K_W'(11): v = R_W'(46);
      K_W'(12): v = R_W'(23);
      K_W'(13): v = R_W'(12);
      K_W'(14): v = R_W'(6);
      default:  v = '0;
    endcase
    return v;
  endfunction

  // Operand decode and conversion to signed fixed point.
  logic                 op_sign;
  logic [EXP_WIDTH-1:0] op_exp;
  logic [MAN_WIDTH-1:0] op_man;
  logic [MAN_WIDTH:0]   op_sig;
  logic [MAG_W-1:0]     op_mag;
  logic [X_W-1:0]       op_fix;

  always_comb begin
    op_sign = data_i[EXP_WIDTH+MAN_WIDTH];
    op_exp  = data_i[EXP_WIDTH+MAN_WIDTH-1:MAN_WIDTH];
    op_man  = data_i[MAN_WIDTH-1:0];
    op_sig  = {1'b1, op_man};
    if (op_exp >= EXP_ONE) begin
      op_mag = MAG_W'(op_sig) << (op_exp - EXP_ONE);
    end else begin
      op_mag = MAG_W'(op_sig) >> (EXP_ONE - op_exp);
    end
    op_fix = op_sign ? (X_W'(0) - {1'b0, op_mag}) : {1'b0, op_mag};
  end

  // Normalisation and round-to-nearest-even of the loop result.
  logic [MAN_WIDTH-1:0]   mant_t, mant_f;
  logic [MAN_WIDTH:0]     mant_r;
  logic                   guard_b, sticky_b, carry_b;
  logic signed [E_W-1:0]  e_norm;

  always_comb begin
    mant_t   = y_q[R_W-1 -: MAN_WIDTH];
    guard_b  = y_q[R_W-1-MAN_WIDTH];
    sticky_b = |y_q[R_W-2-MAN_WIDTH:0];
    mant_r   = {1'b0, mant_t} + (MAN_WIDTH+1)'(guard_b & (sticky_b | mant_t[0]));
    // y can only reach 2.0 through constant rounding; treat it like a rounding carry.
    carry_b  = mant_r[MAN_WIDTH] | y_q[Y_W-1];
    mant_f   = carry_b ? '0 : mant_r[MAN_WIDTH-1:0];
    e_norm   = E_W'(n_q) + E_W'(BIAS) + E_W'(carry_b);
  end

  logic [R_W-1:0] lk;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    r_d         = r_q;
    y_d         = y_q;
    n_d         = n_q;
    result_d    = result_q;
    invalid_d   = invalid_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    lk          = lk_const(k_q);

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          invalid_d   = 1'b0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          state_d     = DONE;
          if (op_exp == EXP_ALL) begin
            if (op_man != '0) begin
              result_d  = QNAN;
              invalid_d = 1'b1;
            end else begin
              result_d = op_sign ? ZERO : POS_INF;
            end
          end else if (op_exp >= EXP_OVF) begin
            result_d    = op_sign ? ZERO : POS_INF;
            overflow_d  = !op_sign;
            underflow_d = op_sign;
          end else if (op_exp < EXP_MIN) begin
            result_d = ONE;
          end else begin
            n_d     = op_fix[X_W-1 -: N_W];
            r_d     = {op_fix[FRAC_W-1:0], GRD_W'(0)};
            y_d     = Y_W'(1) << R_W;
            k_d     = K_W'(1);
            state_d = ITER;
          end
        end
      end
      ITER: begin
        if (r_q >= lk) begin
          r_d = r_q - lk;
          y_d = y_q + (y_q >> k_q);
        end
        if (k_q == K_W'(FRAC_W)) begin
          state_d = NORM;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      NORM: begin
        state_d = DONE;
        if (e_norm >= E_MAX) begin
          result_d   = POS_INF;
          overflow_d = 1'b1;
        end else if (e_norm <= E_ZERO) begin
          result_d    = ZERO;
          underflow_d = 1'b1;
        end else begin
          result_d = {1'b0, e_norm[EXP_WIDTH-1:0], mant_f};
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d     = IDLE;
          invalid_d   = 1'b0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      k_q         <= '0;
      r_q         <= '0;
      y_q         <= '0;
      n_q         <= '0;
      result_q    <= '0;
      invalid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      r_q         <= r_d;
      y_q         <= y_d;
      n_q         <= n_d;
      result_q    <= result_d;
      invalid_q   <= invalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign valid_o     = (state_q == DONE);
  assign result_o    = result_q;
  assign invalid_o   = invalid_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_fexp2_bf16.sv
// Directed bench for fexp2_bf16: table of operands with hand-computed 2^x,
// plus backpressure and mid-operation reset sequences.
module tb_fexp2_bf16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] data_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] result_o;
  logic        invalid_o;
  logic        overflow_o;
  logic        underflow_o;

  fexp2_bf16 dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .invalid_o  (invalid_o),
    .overflow_o (overflow_o),
    .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] din;
    logic [15:0] res;
    int          tol;
    logic        inv;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    int          lat;
    int          diff;
    logic [15:0] held;
    @(negedge clk_i);
    lat = 0;
    while (!ready_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    check("ready_before_accept", 32'(ready_o), 32'd1);
    data_i  = v.din;
    valid_i = 1'b1;
    ready_i = 1'b0;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 40) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(v.lat));
    diff = int'(result_o) - int'(v.res);
    n_tests++;
    if (diff > v.tol || diff < -v.tol) begin
      n_fail++;
      $display("FAIL result x=%h: got %h, expected %h (+/-%0d)", v.din, result_o, v.res, v.tol);
    end
    check("flags", {29'd0, invalid_o, overflow_o, underflow_o}, {29'd0, v.inv, v.ovf, v.unf});
    held = result_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i);
      #1;
      check("backpressure_hold", {14'd0, valid_o, ready_o, result_o}, {14'd0, 1'b1, 1'b0, held});
    end
    ready_i = 1'b1;
    @(posedge clk_i);
    #1 ready_i = 1'b0;
    check("after_consume", {27'd0, valid_o, ready_o, invalid_o, overflow_o, underflow_o}, 32'b01000);
    $display("[TB] x=%h result=%h inv=%b ovf=%b unf=%b lat=%0d hold=%0d",
             v.din, held, v.inv, v.ovf, v.unf, lat, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    vecs[0]  = '{16'h3F80, 16'h4000, 0, 1'b0, 1'b0, 1'b0, 15};  // 1.0
    vecs[1]  = '{16'h3F00, 16'h3FB5, 1, 1'b0, 1'b0, 1'b0, 15};  // 0.5 -> sqrt2
    vecs[2]  = '{16'hBF80, 16'h3F00, 0, 1'b0, 1'b0, 1'b0, 15};  // -1.0
    vecs[3]  = '{16'h42FE, 16'h7F00, 0, 1'b0, 1'b0, 1'b0, 15};  // 127
    vecs[4]  = '{16'h4300, 16'h7F80, 0, 1'b0, 1'b1, 1'b0, 0};   // 128
    vecs[5]  = '{16'h7FC1, 16'h7FC0, 0, 1'b1, 1'b0, 1'b0, 0};   // NaN
    vecs[6]  = '{16'hFF80, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 0};   // -inf
    vecs[7]  = '{16'hC2FE, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 15};  // -127
    vecs[8]  = '{16'h0001, 16'h3F80, 0, 1'b0, 1'b0, 1'b0, 0};   // subnormal
    vecs[9]  = '{16'h4000, 16'h4080, 0, 1'b0, 1'b0, 1'b0, 15};  // 2.0
    vecs[10] = '{16'hBF00, 16'h3F35, 1, 1'b0, 1'b0, 1'b0, 15};  // -0.5
    vecs[11] = '{16'hC2FC, 16'h0080, 0, 1'b0, 1'b0, 1'b0, 15};  // -126, smallest normal
    vecs[12] = '{16'h7F80, 16'h7F80, 0, 1'b0, 1'b0, 1'b0, 0};   // +inf
    vecs[13] = '{16'h3800, 16'h3F80, 0, 1'b0, 1'b0, 1'b0, 0};   // exp 112, too small
    vecs[14] = '{16'h3880, 16'h3F80, 0, 1'b0, 1'b0, 1'b0, 15};  // exp 113, 2^-14
    vecs[15] = '{16'hC300, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 0};   // -128
    vecs[16] = '{16'h4080, 16'h4180, 0, 1'b0, 1'b0, 1'b0, 15};  // 4.0
    vecs[17] = '{16'h4040, 16'h4100, 0, 1'b0, 1'b0, 1'b0, 15};  // 3.0
    vecs[18] = '{16'h8000, 16'h3F80, 0, 1'b0, 1'b0, 1'b0, 0};   // -0

    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = 16'h0000;
    #1;
    check("reset_state", {11'd0, ready_o, valid_o, invalid_o, overflow_o, underflow_o, result_o},
          {11'd0, 5'b10000, 16'h0000});
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 19; i++) begin
      run_vec(vecs[i], 0);
    end

    // Backpressure, then a follow-up operand right after release.
    run_vec(vecs[1], 5);
    run_vec(vecs[4], 5);
    run_vec(vecs[2], 0);

    // Asynchronous reset while iterating, then a clean operation.
    @(negedge clk_i);
    data_i  = 16'h3F00;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check("async_reset_mid_iter", {30'd0, valid_o, ready_o}, 32'b01);
    @(negedge clk_i);
    rst_i = 1'b0;
    rv = vecs[0];
    run_vec(rv, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
